// File: rtl/f15_line_upd.sv
// f15_line_upd: per-bin update engine for one line memory (max-hold or exponential average).
// Reads history 2 cycles ahead, computes the result at t+2, and writes back and streams out at t+3.
module f15_line_upd #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    input  logic              cfg_mode,
    input  logic [3:0]        cfg_shift,
    input  logic              clear,
    output logic [AWIDTH-1:0] mem_rd_addr,
    output logic              mem_rd_ena,
    input  logic [DWIDTH-1:0] mem_rd_data,
    output logic [AWIDTH-1:0] mem_wr_addr,
    output logic [DWIDTH-1:0] mem_wr_data,
    output logic              mem_wr_ena,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              out_valid
);

    typedef enum logic {ST_SEED, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic              clr_pend_q, clr_pend_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              mode_q;
    logic [3:0]        shift_q;

    logic              line_start;
    logic              cur_mode;
    logic [3:0]        cur_shift;

    // stage 1 (t+1)
    logic              s1_valid_q, s1_last_q, s1_seed_q, s1_mode_q;
    logic [DWIDTH-1:0] s1_data_q;
    logic [AWIDTH-1:0] s1_addr_q;
    logic [3:0]        s1_shift_q;
    // stage 2 (t+2)
    logic              s2_valid_q, s2_last_q, s2_seed_q, s2_mode_q;
    logic [DWIDTH-1:0] s2_data_q;
    logic [AWIDTH-1:0] s2_addr_q;
    logic [3:0]        s2_shift_q;
    // output stage (t+3)
    logic              o_valid_q, o_last_q;
    logic [DWIDTH-1:0] o_data_q;
    logic [AWIDTH-1:0] o_addr_q;

    logic signed [DWIDTH:0] diff;
    logic [DWIDTH-1:0]      result;

    // The first bin of a line uses the live config; later bins use the value latched on that first bin.
    assign line_start = (cnt_q == '0);
    assign cur_mode   = line_start ? cfg_mode  : mode_q;
    assign cur_shift  = line_start ? cfg_shift : shift_q;

    assign mem_rd_addr = cnt_q;
    assign mem_rd_ena  = in_valid & (state_q == ST_RUN);

    assign out_data    = o_data_q;
    assign out_last    = o_last_q;
    assign out_valid   = o_valid_q;
    assign mem_wr_addr = o_addr_q;
    assign mem_wr_data = o_data_q;
    assign mem_wr_ena  = o_valid_q;

    // Next state: FSM moves only on an accepted last bin; clear is only remembered while in RUN.
    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        cnt_d      = cnt_q;
        if (clear && (state_q == ST_RUN)) begin
            clr_pend_d = 1'b1;
        end
        if (in_valid) begin
            cnt_d = in_last ? '0 : cnt_q + AWIDTH'(1);
            if (in_last) begin
                if ((state_q == ST_RUN) && (clr_pend_q || clear)) begin
                    state_d    = ST_SEED;
                    clr_pend_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    // Control registers: state, pending clear, bin counter and line-latched configuration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_SEED;
            clr_pend_q <= 1'b0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            cnt_q      <= cnt_d;
            if (in_valid && line_start) begin
                mode_q  <= cfg_mode;
                shift_q <= cfg_shift;
            end
        end
    end

    // Update arithmetic at t+2, when the history word arrives from the line memory.
    always_comb begin
        diff   = $signed({1'b0, s2_data_q}) - $signed({1'b0, mem_rd_data});
        result = s2_data_q;
        if (!s2_seed_q) begin
            if (s2_mode_q) begin
                // result stays between old and in, so truncation never wraps
                result = mem_rd_data + DWIDTH'(diff >>> s2_shift_q);
            end else begin
                result = (s2_data_q > mem_rd_data) ? s2_data_q : mem_rd_data;
            end
        end
    end

    // Pipeline stages carrying bin context alongside the memory read latency, then the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s1_last_q <= 1'b0; s1_seed_q <= 1'b0; s1_mode_q <= 1'b0;
            s1_data_q  <= '0;   s1_addr_q <= '0;   s1_shift_q <= '0;
            s2_valid_q <= 1'b0; s2_last_q <= 1'b0; s2_seed_q <= 1'b0; s2_mode_q <= 1'b0;
            s2_data_q  <= '0;   s2_addr_q <= '0;   s2_shift_q <= '0;
            o_valid_q  <= 1'b0; o_last_q  <= 1'b0; o_data_q  <= '0;   o_addr_q  <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_last_q  <= in_valid & in_last;
            s1_seed_q  <= (state_q == ST_SEED);
            s1_mode_q  <= cur_mode;
            s1_shift_q <= cur_shift;
            s1_data_q  <= in_data;
            s1_addr_q  <= cnt_q;

            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_seed_q  <= s1_seed_q;
            s2_mode_q  <= s1_mode_q;
            s2_shift_q <= s1_shift_q;
            s2_data_q  <= s1_data_q;
            s2_addr_q  <= s1_addr_q;

            o_valid_q  <= s2_valid_q;
            o_last_q   <= s2_valid_q & s2_last_q;
            if (s2_valid_q) begin
                o_data_q <= result;
                o_addr_q <= s2_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_f15_line_upd.sv
// Testbench for f15_line_upd with a behavioural 2-cycle line memory (zero output when read is disabled).
module tb_f15_line_upd;

    localparam int AW = 12;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_last, in_valid, cfg_mode, clear;
    logic [3:0]    cfg_shift;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic          mem_rd_ena, mem_wr_ena;
    logic [DW-1:0] mem_rd_data, mem_wr_data, out_data;
    logic          out_last, out_valid;

    f15_line_upd #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .clear(clear),
        .mem_rd_addr(mem_rd_addr), .mem_rd_ena(mem_rd_ena), .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // line memory model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd1 = '0;
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem_rd_data = '0;
    end
    always @(posedge clk) begin
        if (mem_wr_ena) mem[mem_wr_addr] <= mem_wr_data;
        rd1         <= mem_rd_ena ? mem[mem_rd_addr] : '0;
        mem_rd_data <= rd1;
    end

    // output monitor
    logic [DW-1:0] oq_data[$];
    logic [DW-1:0] oq_wdata[$];
    logic [AW-1:0] oq_waddr[$];
    logic          oq_last[$];
    logic          oq_wena[$];
    int            oq_cyc[$];
    int            in_cyc_q[$];
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            oq_data.push_back(out_data);
            oq_wdata.push_back(mem_wr_data);
            oq_waddr.push_back(mem_wr_addr);
            oq_last.push_back(out_last);
            oq_wena.push_back(mem_wr_ena);
            oq_cyc.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [DW-1:0] vec[$];
    logic [DW-1:0] expv[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_wr_ena", mem_wr_ena, 0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        check("rst_rd_ena", mem_rd_ena, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        rst_n = 1'b1;
        oq_data.delete(); oq_wdata.delete(); oq_waddr.delete();
        oq_last.delete(); oq_wena.delete(); oq_cyc.delete(); in_cyc_q.delete();
    endtask

    task automatic drive_bin(input logic [DW-1:0] d, input logic last, input logic exp_rd,
                             input int addr, input logic clr);
        in_data = d; in_last = last; in_valid = 1'b1; clear = clr;
        in_cyc_q.push_back(cyc);
        #1;
        check($sformatf("rd_ena_bin%0d", addr), mem_rd_ena, exp_rd);
        check($sformatf("rd_addr_bin%0d", addr), mem_rd_addr, addr);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    endtask

    // sends vec as one line; clr_at/tog_at = bin index for clear pulse / cfg_mode toggle (-1 = none)
    task automatic send_line(input logic exp_rd, input int clr_at, input int tog_at, input int gap);
        for (int k = 0; k < vec.size(); k++) begin
            drive_bin(vec[k], k == vec.size() - 1, exp_rd, k, k == clr_at);
            if (k == tog_at) cfg_mode = ~cfg_mode;
            if (gap > 0 && k < vec.size() - 1) idle(gap);
        end
    endtask

    // checks expv against the captured outputs; n = line length
    task automatic check_out(input string tag, input int n);
        for (int k = 0; k < expv.size(); k++) begin
            check($sformatf("%s_present%0d", tag, k), oq_data.size() > 0, 1);
            if (oq_data.size() > 0 && in_cyc_q.size() > 0) begin
                check($sformatf("%s_data%0d", tag, k), oq_data.pop_front(), expv[k]);
                check($sformatf("%s_wdata%0d", tag, k), oq_wdata.pop_front(), expv[k]);
                check($sformatf("%s_waddr%0d", tag, k), oq_waddr.pop_front(), k % n);
                check($sformatf("%s_last%0d", tag, k), oq_last.pop_front(), (k % n) == n - 1);
                check($sformatf("%s_wena%0d", tag, k), oq_wena.pop_front(), 1);
                check($sformatf("%s_lat%0d", tag, k), oq_cyc.pop_front() - in_cyc_q.pop_front(), 3);
            end
        end
        check($sformatf("%s_extra", tag), oq_data.size(), 0);
    endtask

    initial begin
        cfg_mode = 1'b0; cfg_shift = 4'd0;
        // 1: seed line of 8 bins
        do_reset();
        vec = '{0, 10, 20, 30, 40, 50, 60, 70};
        send_line(1'b0, -1, -1, 0);
        idle(5);
        expv = '{0, 10, 20, 30, 40, 50, 60, 70};
        check_out("t1", 8);

        // 2: max-hold, two back-to-back 4-bin lines
        do_reset();
        cfg_mode = 1'b0;
        vec = '{5, 50, 5, 50};
        send_line(1'b0, -1, -1, 0);
        vec = '{40, 40, 40, 40};
        send_line(1'b1, -1, -1, 0);
        idle(5);
        expv = '{5, 50, 5, 50, 40, 50, 40, 50};
        check_out("t2", 4);
        check("t2_mem0", mem[0], 40);
        check("t2_mem1", mem[1], 50);
        check("t2_mem2", mem[2], 40);
        check("t2_mem3", mem[3], 50);

        // 3: average, shift 2, then shift 0
        do_reset();
        cfg_mode = 1'b1; cfg_shift = 4'd2;
        vec = '{100, 100, 100, 100};
        send_line(1'b0, -1, -1, 0); idle(5);
        expv = '{100, 100, 100, 100}; check_out("t3a", 4);
        vec = '{200, 200, 200, 200};
        send_line(1'b1, -1, -1, 0); idle(5);
        expv = '{125, 125, 125, 125}; check_out("t3b", 4);
        send_line(1'b1, -1, -1, 0); idle(5);
        expv = '{143, 143, 143, 143}; check_out("t3c", 4);
        cfg_shift = 4'd0;
        send_line(1'b1, -1, -1, 0); idle(5);
        expv = '{200, 200, 200, 200}; check_out("t3d", 4);

        // 4: decay from full scale, floor on negative diff, 0 over 0
        do_reset();
        cfg_mode = 1'b1; cfg_shift = 4'd1;
        vec = '{262143, 0, 262143, 0};
        send_line(1'b0, -1, -1, 0); idle(5);
        expv = '{262143, 0, 262143, 0}; check_out("t4a", 4);
        vec = '{0, 0, 0, 0};
        send_line(1'b1, -1, -1, 0); idle(5);
        expv = '{131071, 0, 131071, 0}; check_out("t4b", 4);

        // 5: clear mid-line in RUN; next line reseeds; clear during SEED is absorbed
        vec = '{1000, 1000, 1000, 1000};
        send_line(1'b1, 1, -1, 0); idle(5);
        expv = '{66035, 500, 66035, 500}; check_out("t5a", 4);
        vec = '{7, 8, 9, 10};
        send_line(1'b0, 2, -1, 0); idle(5);
        expv = '{7, 8, 9, 10}; check_out("t5b", 4);

        // 6: gapped input, cfg_mode toggled mid-line takes effect on the next line
        vec = '{20, 20, 20, 20};
        send_line(1'b1, -1, 1, 2); idle(5);
        expv = '{13, 14, 14, 15}; check_out("t6a", 4);
        vec = '{14, 14, 14, 14};
        send_line(1'b1, -1, -1, 0); idle(5);
        expv = '{14, 14, 14, 15}; check_out("t6b", 4);

        // 7: clear coincident with in_last -> very next line is SEED
        vec = '{1, 1, 1, 1};
        send_line(1'b1, 3, -1, 0); idle(5);
        expv = '{14, 14, 14, 15}; check_out("t7a", 4);
        vec = '{3, 3, 3, 3};
        send_line(1'b0, -1, -1, 0); idle(5);
        expv = '{3, 3, 3, 3}; check_out("t7b", 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
